// File: rtl/wb_arbiter.sv
// Write-back arbiter: two requesters (A = ALU, B = load/multicycle) share one
// register-file write port. Round-robin on contention, registered write port,
// saturating count of cycles in which a valid requester was refused.
module wb_arbiter #(
  parameter int WIDTH = 32,
  parameter int CNTW  = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             a_valid,
  input  logic [4:0]       a_addr,
  input  logic [WIDTH-1:0] a_data,
  output logic             a_ready,
  input  logic             b_valid,
  input  logic [4:0]       b_addr,
  input  logic [WIDTH-1:0] b_data,
  output logic             b_ready,
  output logic             we3,
  output logic [4:0]       wa3,
  output logic [WIDTH-1:0] wd3,
  output logic             last_b,
  output logic [CNTW-1:0]  stall_cnt
);

  localparam logic [CNTW-1:0] STALL_MAX = '1;

  logic             xfer;
  logic [4:0]       xfer_addr;
  logic [WIDTH-1:0] xfer_data;
  logic             contention;

  // Grant decision: a lone requester always wins; on contention the one that
  // did not win most recently gets the port. Nothing is granted in reset.
  always_comb begin
    a_ready = 1'b0;
    b_ready = 1'b0;
    if (!reset) begin
      if (a_valid && b_valid) begin
        a_ready = last_b;
        b_ready = !last_b;
      end else begin
        a_ready = a_valid;
        b_ready = b_valid;
      end
    end
  end

  // Mux the winning requester onto the write path.
  always_comb begin
    xfer       = a_ready || b_ready;
    xfer_addr  = b_ready ? b_addr : a_addr;
    xfer_data  = b_ready ? b_data : a_data;
    contention = a_valid && b_valid;
  end

  // Register the write port, priority flag and stall counter; x0 writes are
  // accepted but suppressed, and the port holds its last address/data.
  always_ff @(posedge clk) begin
    if (reset) begin
      we3       <= 1'b0;
      wa3       <= '0;
      wd3       <= '0;
      last_b    <= 1'b0;
      stall_cnt <= '0;
    end else begin
      we3 <= xfer && (xfer_addr != 5'd0);
      if (xfer && (xfer_addr != 5'd0)) begin
        wa3 <= xfer_addr;
        wd3 <= xfer_data;
      end
      if (xfer) begin
        last_b <= b_ready;
      end
      if (contention && (stall_cnt != STALL_MAX)) begin
        stall_cnt <= stall_cnt + 1'b1;
      end
    end
  end

endmodule
